// File: rtl/dvp_pixel_assembler.sv
// DVP byte-to-pixel assembler with frame/line tracking and coordinates.
// Single pclk domain; synchronous active-high reset.
module dvp_pixel_assembler #(
    parameter int IN_WIDTH    = 8,
    parameter int MAX_BYTES   = 3,
    parameter int COORD_WIDTH = 11
) (
    input  logic                          pclk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          capture_mode,
    input  logic [1:0]                    bytes_per_pixel,
    input  logic                          byte_swap,
    input  logic                          vsynch,
    input  logic                          href,
    input  logic [IN_WIDTH-1:0]           input_8_bit,
    output logic [IN_WIDTH*MAX_BYTES-1:0] pixel_out,
    output logic                          pixel_valid,
    output logic [COORD_WIDTH-1:0]        pixel_x,
    output logic [COORD_WIDTH-1:0]        pixel_y,
    output logic                          line_end,
    output logic                          frame_start,
    output logic                          frame_end,
    output logic                          image_frame_active,
    output logic [7:0]                    frame_count,
    output logic                          line_error
);

    localparam int PW = IN_WIDTH * MAX_BYTES;
    localparam logic [1:0] MAXB = 2'(MAX_BYTES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                 state;
    logic                   vsynch_d;
    logic                   href_d;
    logic [1:0]             bpp;
    logic                   swap;
    logic [1:0]             byte_idx;
    logic [PW-1:0]          acc;
    logic [PW-1:0]          acc_next;
    logic [COORD_WIDTH-1:0] x;
    logic [COORD_WIDTH-1:0] y;
    logic [COORD_WIDTH-1:0] x_inc;
    logic [COORD_WIDTH-1:0] y_inc;
    logic [1:0]             bpp_clamped;
    logic [1:0]             slot;
    logic                   last_byte;

    always_comb begin
        bpp_clamped = bytes_per_pixel;
        if (bytes_per_pixel == 2'd0) begin
            bpp_clamped = 2'd1;
        end else if (bytes_per_pixel > MAXB) begin
            bpp_clamped = MAXB;
        end
    end

    // Byte 0 lands in the top used slot unless the stream is LSB-first.
    assign slot      = swap ? byte_idx : (bpp - 2'd1 - byte_idx);
    assign last_byte = (byte_idx == bpp - 2'd1);
    assign x_inc     = (&x) ? x : x + 1'b1;
    assign y_inc     = (&y) ? y : y + 1'b1;

    // A fresh pixel starts from zero so unused upper slots stay clear.
    always_comb begin
        acc_next = (byte_idx == 2'd0) ? '0 : acc;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (slot == 2'(i)) begin
                acc_next[i*IN_WIDTH +: IN_WIDTH] = input_8_bit;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            state              <= IDLE;
            vsynch_d           <= 1'b0;
            href_d             <= 1'b0;
            bpp                <= 2'd0;
            swap               <= 1'b0;
            byte_idx           <= 2'd0;
            acc                <= '0;
            x                  <= '0;
            y                  <= '0;
            pixel_out          <= '0;
            pixel_valid        <= 1'b0;
            pixel_x            <= '0;
            pixel_y            <= '0;
            line_end           <= 1'b0;
            frame_start        <= 1'b0;
            frame_end          <= 1'b0;
            image_frame_active <= 1'b0;
            frame_count        <= 8'd0;
            line_error         <= 1'b0;
        end else begin
            vsynch_d    <= vsynch;
            href_d      <= href;
            pixel_valid <= 1'b0;
            line_end    <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            if (!enable) begin
                state              <= IDLE;
                byte_idx           <= 2'd0;
                image_frame_active <= 1'b0;
            end else begin
                case (state)
                    IDLE: state <= SYNC;
                    SYNC: begin
                        if (vsynch_d && !vsynch) begin
                            state              <= ACTIVE;
                            frame_start        <= 1'b1;
                            image_frame_active <= 1'b1;
                            bpp                <= bpp_clamped;
                            swap               <= byte_swap;
                            x                  <= '0;
                            y                  <= '0;
                            byte_idx           <= 2'd0;
                            line_error         <= 1'b0;
                        end
                    end
                    ACTIVE: begin
                        if (vsynch) begin
                            frame_end          <= 1'b1;
                            frame_count        <= frame_count + 8'd1;
                            byte_idx           <= 2'd0;
                            image_frame_active <= 1'b0;
                            state <= capture_mode ? SYNC : DONE;
                        end else if (href) begin
                            acc <= acc_next;
                            if (last_byte) begin
                                pixel_out   <= acc_next;
                                pixel_valid <= 1'b1;
                                pixel_x     <= x;
                                pixel_y     <= y;
                                x           <= x_inc;
                                byte_idx    <= 2'd0;
                            end else begin
                                byte_idx <= byte_idx + 2'd1;
                            end
                        end else if (href_d) begin
                            line_end <= 1'b1;
                            x        <= '0;
                            y        <= y_inc;
                            byte_idx <= 2'd0;
                            if (byte_idx != 2'd0) begin
                                line_error <= 1'b1;
                            end
                        end
                    end
                    DONE: state <= DONE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
